// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for the RiSC-16 core.
// Three requesters (fetch, data, debug) share one word-addressed memory. At
// most one command issues per cycle. Read data is steered back to its owner
// through a READ_LAT-deep owner-tag pipeline that matches the memory latency.
module mem_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 16,
  parameter int READ_LAT   = 1,
  parameter int STARVE_LIM = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int          SW      = $clog2(STARVE_LIM + 1);
  localparam logic [SW-1:0] LIM   = SW'(STARVE_LIM);
  localparam logic [1:0]  OWN_IF  = 2'd0;
  localparam logic [1:0]  OWN_DM  = 2'd1;
  localparam logic [1:0]  OWN_DBG = 2'd2;

  typedef enum logic [1:0] {SEL_NONE, SEL_IF, SEL_DM, SEL_DBG} sel_e;

  sel_e                      sel;
  logic [SW-1:0]             starve_cnt_q, starve_cnt_d;
  logic [READ_LAT-1:0]       vld_pipe_q, vld_pipe_d;
  logic [READ_LAT-1:0][1:0]  own_pipe_q, own_pipe_d;
  logic [AW-1:0]             addr_q, addr_d;
  logic [DW-1:0]             wdata_q, wdata_d;
  logic [1:0]                rd_own;
  logic                      if_starved;
  logic                      tail_vld;
  logic [1:0]                tail_own;

  assign if_starved = (starve_cnt_q == LIM);

  // Winner select: DBG > DM > IF, except a starved fetch jumps ahead of DM.
  always_comb begin
    sel = SEL_NONE;
    if (!reset) begin
      if (dbg_req)                              sel = SEL_DBG;
      else if (dm_req && !(if_req && if_starved)) sel = SEL_DM;
      else if (if_req)                          sel = SEL_IF;
    end
  end

  // Grant pulses and memory command; address/wdata hold when nobody wins.
  always_comb begin
    if_gnt  = 1'b0;
    dm_gnt  = 1'b0;
    dbg_gnt = 1'b0;
    mem_en  = 1'b0;
    mem_we  = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_own  = OWN_IF;
    case (sel)
      SEL_IF: begin
        if_gnt = 1'b1;
        mem_en = 1'b1;
        addr_d = if_addr;
      end
      SEL_DM: begin
        dm_gnt  = 1'b1;
        mem_en  = 1'b1;
        mem_we  = dm_we;
        addr_d  = dm_addr;
        wdata_d = dm_wdata;
        rd_own  = OWN_DM;
      end
      SEL_DBG: begin
        dbg_gnt = 1'b1;
        mem_en  = 1'b1;
        mem_we  = dbg_we;
        addr_d  = dbg_addr;
        wdata_d = dbg_wdata;
        rd_own  = OWN_DBG;
      end
      default: ;
    endcase
  end

  assign mem_addr  = reset ? '0 : addr_d;
  assign mem_wdata = reset ? '0 : wdata_d;

  // Fetch starvation counter: cleared on fetch grant, saturates at the limit.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (if_gnt)                      starve_cnt_d = '0;
    else if (if_req && !if_starved)  starve_cnt_d = starve_cnt_q + 1'b1;
  end

  // Owner-tag shift register; a write enters as an empty slot.
  always_comb begin
    vld_pipe_d[0] = mem_en & ~mem_we;
    own_pipe_d[0] = rd_own;
    for (int i = 1; i < READ_LAT; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      own_pipe_d[i] = own_pipe_q[i-1];
    end
  end

  // State registers; reset also drops any reads still in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q <= '0;
      vld_pipe_q   <= '0;
      own_pipe_q   <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      vld_pipe_q   <= vld_pipe_d;
      own_pipe_q   <= own_pipe_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign tail_vld   = vld_pipe_q[READ_LAT-1] & ~reset;
  assign tail_own   = own_pipe_q[READ_LAT-1];
  assign if_rvalid  = tail_vld && (tail_own == OWN_IF);
  assign dm_rvalid  = tail_vld && (tail_own == OWN_DM);
  assign dbg_rvalid = tail_vld && (tail_own == OWN_DBG);
  assign rdata      = mem_rdata;

endmodule
